// File: rtl/water_supply_pkg.sv
// Shared definitions for the water-supply inlet controller.
// Holds the FSM state type, the latched fault-cause codes and the
// sensor-consistency helper used by the top-level controller.
package water_supply_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2,
    ERROR   = 2'd3
  } ws_state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_CONFLICT = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

  // A higher sensor wet while a lower one is dry is physically impossible
  // for a healthy sensor stack; lvl is {high, mid, low}.
  function automatic logic level_conflict(input logic [2:0] lvl);
    return (lvl[1] & ~lvl[0]) | (lvl[2] & ~lvl[1]);
  endfunction

endpackage

// File: rtl/level_debouncer.sv
// Single water-level sensor conditioner: two-flop synchroniser followed by
// a debounce counter. The clean output only changes after DEBOUNCE_CYCLES
// consecutive synchronised samples disagree with it.
// Ports:
//   clock - system clock, rising edge
//   reset - asynchronous, active-high
//   raw   - raw sensor input, asynchronous to clock
//   clean - debounced sensor value
module level_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic clean
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          clean_r;
  logic [CW-1:0] cnt_r;

  // Synchronise the raw input and count consecutive disagreeing samples.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      clean_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      if (sync2_r != clean_r) begin
        if (cnt_r == CNT_LAST) begin
          clean_r <= sync2_r;
          cnt_r   <= {CW{1'b0}};
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end else begin
        cnt_r <= {CW{1'b0}};
      end
    end
  end

  assign clean = clean_r;

endmodule

// File: rtl/water_supply_controller.sv
// Tank inlet valve sequencer. Debounces the low/mid/high level sensors,
// supervises their consistency and the fill duration, and drives the valve
// with hysteresis (refill only once the low sensor goes dry).
// Ports:
//   clock, reset        - clock (rising edge), async active-high reset
//   enable              - operator enable; 0 closes the valve unless in ERROR
//   clear_error         - single-cycle request to leave ERROR
//   low/mid/high_level  - raw level sensors, asynchronous to clock
//   valve_open          - inlet valve drive (registered)
//   alarm               - fault indicator (registered)
//   state               - current FSM state
//   error_code          - latched fault cause (none/conflict/timeout)
//   level               - debounced {high, mid, low}
module water_supply_controller
  import water_supply_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CONFLICT_CYCLES = 8,
  parameter int FILL_TIMEOUT    = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       clear_error,
  input  logic       low_level,
  input  logic       mid_level,
  input  logic       high_level,
  output logic       valve_open,
  output logic       alarm,
  output logic [1:0] state,
  output logic [1:0] error_code,
  output logic [2:0] level
);

  localparam int CCW = $clog2(CONFLICT_CYCLES + 1);
  localparam int FCW = $clog2(FILL_TIMEOUT + 1);
  localparam logic [CCW-1:0] CONF_SAT  = CCW'(CONFLICT_CYCLES);
  localparam logic [CCW-1:0] CONF_LAST = CCW'(CONFLICT_CYCLES - 1);
  localparam logic [FCW-1:0] FILL_LAST = FCW'(FILL_TIMEOUT - 1);

  logic [2:0]     level_s;
  logic [2:0]     level_prev_r;
  logic           conflict_s;
  logic           conflict_fault_s;
  logic           rise_s;
  logic           timeout_s;
  logic [CCW-1:0] conflict_cnt_r;
  logic [FCW-1:0] fill_cnt_r;
  ws_state_t      state_r;
  ws_state_t      next_state_s;
  logic [1:0]     err_r;
  logic [1:0]     err_next_s;
  logic           valve_r;
  logic           alarm_r;

  level_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_low (
    .clock(clock), .reset(reset), .raw(low_level),  .clean(level_s[0])
  );
  level_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mid (
    .clock(clock), .reset(reset), .raw(mid_level),  .clean(level_s[1])
  );
  level_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_high (
    .clock(clock), .reset(reset), .raw(high_level), .clean(level_s[2])
  );

  assign conflict_s       = level_conflict(level_s);
  assign conflict_fault_s = conflict_s & (conflict_cnt_r == CONF_LAST);
  // Any sensor getting wet counts as fill progress.
  assign rise_s           = |(level_s & ~level_prev_r);
  assign timeout_s        = (state_r == FILLING) & (fill_cnt_r == FILL_LAST);

  // Next-state and fault-cause selection.
  always_comb begin
    next_state_s = state_r;
    err_next_s   = err_r;
    if (state_r == ERROR) begin
      // Recovery only once the sensor stack looks sane again.
      if (clear_error && !conflict_s) begin
        next_state_s = IDLE;
        err_next_s   = ERR_NONE;
      end else begin
        next_state_s = ERROR;
      end
    end else if (conflict_fault_s) begin
      next_state_s = ERROR;
      err_next_s   = ERR_CONFLICT;
    end else begin
      case (state_r)
        IDLE: begin
          if (enable && !level_s[0]) begin
            next_state_s = FILLING;
          end else if (enable && level_s[2]) begin
            next_state_s = FULL;
          end else begin
            next_state_s = IDLE;
          end
        end
        FILLING: begin
          // Reaching high beats a simultaneous timeout.
          if (level_s[2]) begin
            next_state_s = FULL;
          end else if (timeout_s) begin
            next_state_s = ERROR;
            err_next_s   = ERR_TIMEOUT;
          end else if (!enable) begin
            next_state_s = IDLE;
          end else begin
            next_state_s = FILLING;
          end
        end
        FULL: begin
          if (!enable) begin
            next_state_s = IDLE;
          end else if (!level_s[0]) begin
            next_state_s = FILLING;
          end else begin
            next_state_s = FULL;
          end
        end
        default: begin
          next_state_s = IDLE;
        end
      endcase
    end
  end

  // State, fault cause and registered actuator outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      err_r   <= ERR_NONE;
      valve_r <= 1'b0;
      alarm_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      err_r   <= err_next_s;
      valve_r <= (next_state_s == FILLING);
      alarm_r <= (next_state_s == ERROR);
    end
  end

  // Persistence counter for sensor conflicts, saturating.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      conflict_cnt_r <= {CCW{1'b0}};
    end else if (!conflict_s) begin
      conflict_cnt_r <= {CCW{1'b0}};
    end else if (conflict_cnt_r != CONF_SAT) begin
      conflict_cnt_r <= conflict_cnt_r + CCW'(1);
    end else begin
      conflict_cnt_r <= conflict_cnt_r;
    end
  end

  // Fill supervision timer: restarts on entry to FILLING and on progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fill_cnt_r   <= {FCW{1'b0}};
      level_prev_r <= 3'b000;
    end else begin
      level_prev_r <= level_s;
      if ((state_r != FILLING) && (next_state_s == FILLING)) begin
        fill_cnt_r <= {FCW{1'b0}};
      end else if (state_r == FILLING) begin
        if (rise_s) begin
          fill_cnt_r <= {FCW{1'b0}};
        end else begin
          fill_cnt_r <= fill_cnt_r + FCW'(1);
        end
      end else begin
        fill_cnt_r <= fill_cnt_r;
      end
    end
  end

  assign valve_open = valve_r;
  assign alarm      = alarm_r;
  assign state      = state_r;
  assign error_code = err_r;
  assign level      = level_s;

endmodule

// File: tb/tb_water_supply_controller.sv
// Self-checking bench for water_supply_controller: directed scenarios plus
// randomized sensor sequences, compared every cycle with a behavioural model.
module tb_water_supply_controller;

  localparam int DB = 4;
  localparam int CF = 8;
  localparam int FT = 50;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       clear_error;
  logic       low_level;
  logic       mid_level;
  logic       high_level;
  logic       valve_open;
  logic       alarm;
  logic [1:0] state;
  logic [1:0] error_code;
  logic [2:0] level;

  always #5 clock = ~clock;

  water_supply_controller #(
    .DEBOUNCE_CYCLES(DB), .CONFLICT_CYCLES(CF), .FILL_TIMEOUT(FT)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .clear_error(clear_error),
    .low_level(low_level), .mid_level(mid_level), .high_level(high_level),
    .valve_open(valve_open), .alarm(alarm), .state(state),
    .error_code(error_code), .level(level)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [2:0] raw_q[$];   // raw values still travelling through the synchroniser
  logic [2:0] hist_q[$];  // most recent DB synchronised samples
  logic [2:0] m_level, m_prev;
  int m_state, m_err, m_crun, edge_n, fill_mark;
  bit m_valve, m_alarm;

  task automatic model_reset();
    raw_q = {3'b000, 3'b000};
    hist_q = {};
    m_level = 3'b000; m_prev = 3'b000;
    m_state = 0; m_err = 0; m_crun = 0;
    m_valve = 1'b0; m_alarm = 1'b0;
    edge_n = 0; fill_mark = 0;
  endtask

  task automatic model_edge();
    bit conflict, fault, timeout, rise, all_diff;
    int nxt;
    logic [2:0] sample, new_level;
    conflict = (m_level[1] && !m_level[0]) || (m_level[2] && !m_level[1]);
    fault    = conflict && (m_crun == CF - 1);
    rise     = |(m_level & ~m_prev);
    timeout  = (m_state == 1) && (edge_n - fill_mark == FT);
    nxt = m_state;
    if (m_state == 3) begin
      if (clear_error && !conflict) begin nxt = 0; m_err = 0; end
    end else if (fault) begin
      nxt = 3; m_err = 1;
    end else if (m_state == 0) begin
      if (enable && !m_level[0]) nxt = 1;
      else if (enable && m_level[2]) nxt = 2;
    end else if (m_state == 1) begin
      if (m_level[2]) nxt = 2;
      else if (timeout) begin nxt = 3; m_err = 2; end
      else if (!enable) nxt = 0;
    end else begin
      if (!enable) nxt = 0;
      else if (!m_level[0]) nxt = 1;
    end
    if (nxt == 1 && m_state != 1) fill_mark = edge_n;
    else if (m_state == 1 && rise) fill_mark = edge_n;
    // Sensor path: a raw value is seen by the debouncer two edges later, and
    // a bit flips once the last DB samples all disagree with it.
    sample = raw_q.pop_front();
    raw_q.push_back({high_level, mid_level, low_level});
    hist_q.push_back(sample);
    if (hist_q.size() > DB) void'(hist_q.pop_front());
    new_level = m_level;
    for (int b = 0; b < 3; b++) begin
      all_diff = (hist_q.size() == DB);
      foreach (hist_q[i]) if (hist_q[i][b] == m_level[b]) all_diff = 1'b0;
      if (all_diff) new_level[b] = ~m_level[b];
    end
    m_crun  = conflict ? m_crun + 1 : 0;
    m_prev  = m_level;
    m_level = new_level;
    m_state = nxt;
    m_valve = (nxt == 1);
    m_alarm = (nxt == 3);
    edge_n++;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic compare_all();
    check_eq("state", state, m_state);
    check_eq("valve", valve_open, m_valve);
    check_eq("alarm", alarm, m_alarm);
    check_eq("error_code", error_code, m_err);
    check_eq("level", level, m_level);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_sensors(input logic [2:0] v);
    {high_level, mid_level, low_level} = v;
  endtask

  task automatic async_reset();
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_valve_async", valve_open, 0);
    model_reset();
    @(posedge clock);
    #2;
    reset = 1'b0;
    compare_all();
    check_eq("rst_state", state, 0);
    check_eq("rst_level", level, 0);
  endtask

  initial begin
    logic [2:0] pat;
    int hold;
    reset = 1'b1; enable = 1'b0; clear_error = 1'b0;
    set_sensors(3'b000);
    model_reset();
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
    compare_all();
    check_eq("reset_state", state, 0);
    check_eq("reset_valve", valve_open, 0);
    check_eq("reset_err", error_code, 0);

    // Fill from empty, sensors rising one at a time.
    enable = 1'b1;
    steps(2);
    check_eq("fill_start_state", state, 1);
    check_eq("fill_start_valve", valve_open, 1);
    set_sensors(3'b001); steps(20);
    set_sensors(3'b011); steps(20);
    set_sensors(3'b111); steps(2 + DB);
    check_eq("pre_full_state", state, 1);
    step();
    check_eq("full_state", state, 2);
    check_eq("full_valve", valve_open, 0);

    // Hysteresis: only losing low triggers a refill.
    set_sensors(3'b011); steps(20);
    set_sensors(3'b001); steps(20);
    check_eq("hyst_state", state, 2);
    check_eq("hyst_valve", valve_open, 0);
    set_sensors(3'b000); steps(2 + DB + 1);
    check_eq("refill_state", state, 1);
    check_eq("refill_valve", valve_open, 1);

    // Conflict fault and guarded recovery.
    set_sensors(3'b010); steps(20);
    check_eq("conf_state", state, 3);
    check_eq("conf_err", error_code, 1);
    check_eq("conf_alarm", alarm, 1);
    check_eq("conf_valve", valve_open, 0);
    clear_error = 1'b1; step(); clear_error = 1'b0;
    check_eq("conf_clear_ignored", state, 3);
    set_sensors(3'b011); steps(10);
    clear_error = 1'b1; step(); clear_error = 1'b0;
    check_eq("conf_clear_state", state, 0);
    check_eq("conf_clear_err", error_code, 0);

    // Short glitch on high while filling at 001.
    set_sensors(3'b000); steps(8);
    set_sensors(3'b001); steps(10);
    set_sensors(3'b101); steps(3);
    set_sensors(3'b001); steps(10);
    check_eq("glitch_level", level, 3'b001);
    check_eq("glitch_state", state, 1);

    // Fill timeout, counted from FILLING entry.
    enable = 1'b0;
    set_sensors(3'b000); steps(10);
    enable = 1'b1; step();
    check_eq("to_entry", state, 1);
    steps(FT - 1);
    check_eq("to_before", state, 1);
    step();
    check_eq("to_state", state, 3);
    check_eq("to_err", error_code, 2);

    // Progress at cycle 40 postpones the timeout.
    clear_error = 1'b1; step(); clear_error = 1'b0;
    step();
    check_eq("to2_entry", state, 1);
    steps(33);
    set_sensors(3'b001); steps(22);
    check_eq("to2_no_timeout", state, 1);

    // Asynchronous reset in the middle of a fill.
    async_reset();

    // Randomized sequences, mostly plausible sensor stacks.
    for (int seg = 0; seg < 200; seg++) begin
      if ($urandom_range(0, 99) < 85) begin
        case ($urandom_range(0, 3))
          0: pat = 3'b000;
          1: pat = 3'b001;
          2: pat = 3'b011;
          default: pat = 3'b111;
        endcase
      end else begin
        pat = 3'($urandom_range(0, 7));
      end
      set_sensors(pat);
      enable = ($urandom_range(0, 99) < 90);
      hold = $urandom_range(1, 25);
      for (int c = 0; c < hold; c++) begin
        clear_error = ($urandom_range(0, 9) == 0);
        step();
      end
      clear_error = 1'b0;
      if ($urandom_range(0, 99) < 3) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
